// File: rtl/cmd_stream_encoder.sv
// cmd_stream_encoder: frames host requests and raw payload into header + exactly-counted payload
// words for the rasterizer command parser, padding short payloads and flagging framing errors.
module cmd_stream_encoder #(
    parameter int CMD_STREAM_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        resetn,
    input  logic                        s_req_valid,
    output logic                        s_req_ready,
    input  logic [3:0]                  s_req_op,
    input  logic [23:0]                 s_req_imm,
    input  logic [15:0]                 s_req_data,
    input  logic                        s_payload_axis_tvalid,
    output logic                        s_payload_axis_tready,
    input  logic                        s_payload_axis_tlast,
    input  logic [CMD_STREAM_WIDTH-1:0] s_payload_axis_tdata,
    output logic                        m_cmd_axis_tvalid,
    input  logic                        m_cmd_axis_tready,
    output logic                        m_cmd_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
    output logic                        busy,
    output logic [1:0]                  err,
    input  logic                        err_clear,
    output logic [15:0]                 cmd_count
);
    localparam int OP_SIZE                  = 4;
    localparam int OP_POS                   = CMD_STREAM_WIDTH - OP_SIZE;
    localparam int TEXTURE_STREAM_SIZE_POS  = 0;
    localparam int TEXTURE_STREAM_SIZE_SIZE = 8;
    localparam int L                        = $clog2(CMD_STREAM_WIDTH / 8);
    localparam logic [3:0] OP_NOP_STREAM      = 4'd0;
    localparam logic [3:0] OP_TEXTURE_STREAM  = 4'd1;
    localparam logic [3:0] OP_RENDER_CONFIG   = 4'd2;
    localparam logic [3:0] OP_FRAMEBUFFER     = 4'd3;
    localparam logic [3:0] OP_TRIANGLE_STREAM = 4'd4;
    localparam logic [3:0] OP_FOG_LUT_STREAM  = 4'd5;

    typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_PAYLOAD, S_PAD} state_t;

    state_t                      r_state;
    logic [13:0]                 r_cnt;
    logic [15:0]                 r_cfg;
    logic                        r_tvalid;
    logic                        r_tlast;
    logic [CMD_STREAM_WIDTH-1:0] r_tdata;
    logic [1:0]                  r_err;
    logic [15:0]                 r_cmd_count;

    logic                                w_free;
    logic                                w_req_fire;
    logic                                w_pay_fire;
    logic                                w_cnt_one;
    logic                                w_known;
    logic [TEXTURE_STREAM_SIZE_SIZE-1:0] w_tex_s;
    logic [31:0]                         w_tex_sh;
    logic [13:0]                         w_tex_n;
    logic [13:0]                         w_n;
    logic [CMD_STREAM_WIDTH-1:0]         w_header;
    logic                                w_err0;
    logic                                w_err1;

    // The output slot can take a new word when empty or draining this cycle.
    assign w_free     = !r_tvalid || m_cmd_axis_tready;
    assign s_req_ready           = resetn && (r_state == S_IDLE) && w_free;
    assign s_payload_axis_tready = resetn && (r_state == S_PAYLOAD) && w_free;
    assign w_req_fire = s_req_valid && s_req_ready;
    assign w_pay_fire = s_payload_axis_tvalid && s_payload_axis_tready;
    assign w_cnt_one  = (r_cnt == 14'd1);

    always_comb begin
        w_known  = s_req_op inside {OP_NOP_STREAM, OP_TEXTURE_STREAM, OP_RENDER_CONFIG,
                                    OP_FRAMEBUFFER, OP_TRIANGLE_STREAM, OP_FOG_LUT_STREAM};
        w_tex_s  = s_req_imm[TEXTURE_STREAM_SIZE_POS +: TEXTURE_STREAM_SIZE_SIZE];
        w_tex_sh = 32'(w_tex_s) - 32'(L);
        w_tex_n  = (w_tex_s == '0) ? 14'd0 : 14'(32'd1 << w_tex_sh);
        w_n      = (s_req_op == OP_TRIANGLE_STREAM) ? 14'(s_req_imm >> L) :
                   (s_req_op == OP_TEXTURE_STREAM)  ? w_tex_n :
                   (s_req_op == OP_FOG_LUT_STREAM)  ? 14'd33 :
                   (s_req_op == OP_RENDER_CONFIG)   ? 14'd1 : 14'd0;
        w_header = (CMD_STREAM_WIDTH'(s_req_op) << OP_POS) | CMD_STREAM_WIDTH'(s_req_imm);
        w_err0   = w_pay_fire && s_payload_axis_tlast && !w_cnt_one;
        w_err1   = (w_req_fire && !w_known) || (w_pay_fire && w_cnt_one && !s_payload_axis_tlast);
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cfg       <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= '0;
            r_err       <= '0;
            r_cmd_count <= '0;
        end else begin
            r_err <= (err_clear ? 2'b00 : r_err) | {w_err1, w_err0};
            if (r_tvalid && m_cmd_axis_tready && r_tlast)
                r_cmd_count <= r_cmd_count + 16'd1;
            if (w_free)
                r_tvalid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_req_fire) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= w_header;
                    r_tlast  <= (w_n == 14'd0);
                    r_cnt    <= w_n;
                    r_cfg    <= s_req_data;
                    r_state  <= (w_n == 14'd0) ? S_IDLE :
                                (s_req_op == OP_RENDER_CONFIG) ? S_CONFIG : S_PAYLOAD;
                end
                S_CONFIG: if (w_free) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= CMD_STREAM_WIDTH'(r_cfg);
                    r_tlast  <= 1'b1;
                    r_state  <= S_IDLE;
                end
                S_PAYLOAD: if (w_pay_fire) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= s_payload_axis_tdata;
                    r_tlast  <= w_cnt_one;
                    r_cnt    <= r_cnt - 14'd1;
                    r_state  <= w_cnt_one ? S_IDLE : s_payload_axis_tlast ? S_PAD : S_PAYLOAD;
                end
                S_PAD: if (w_free) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= '0;
                    r_tlast  <= w_cnt_one;
                    r_cnt    <= r_cnt - 14'd1;
                    r_state  <= w_cnt_one ? S_IDLE : S_PAD;
                end
            endcase
        end
    end

    assign m_cmd_axis_tvalid = r_tvalid;
    assign m_cmd_axis_tlast  = r_tlast;
    assign m_cmd_axis_tdata  = r_tdata;
    assign busy              = (r_state != S_IDLE) || r_tvalid;
    assign err               = r_err;
    assign cmd_count         = r_cmd_count;
endmodule

// File: tb/tb_cmd_stream_encoder.sv
// tb_cmd_stream_encoder: directed command table, back-to-back, backpressure and reset checks
// against hand-computed command streams at CMD_STREAM_WIDTH = 32.
module tb_cmd_stream_encoder;
    localparam logic [3:0] NOP = 4'd0, TEX = 4'd1, CFG = 4'd2, FB = 4'd3, TRI = 4'd4, FOG = 4'd5;

    typedef struct {
        logic [3:0]  op;
        logic [23:0] imm;
        logic [15:0] data;
        int          npay;
        bit          last_on;
        int          exp_n;
        logic [1:0]  exp_err;
    } vec_t;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic [3:0]  s_req_op = '0;
    logic [23:0] s_req_imm = '0;
    logic [15:0] s_req_data = '0;
    logic        s_payload_axis_tvalid = 1'b0;
    logic        s_payload_axis_tready;
    logic        s_payload_axis_tlast = 1'b0;
    logic [31:0] s_payload_axis_tdata = '0;
    logic        m_cmd_axis_tvalid;
    logic        m_cmd_axis_tready = 1'b1;
    logic        m_cmd_axis_tlast;
    logic [31:0] m_cmd_axis_tdata;
    logic        busy;
    logic [1:0]  err;
    logic        err_clear = 1'b0;
    logic [15:0] cmd_count;

    cmd_stream_encoder #(.CMD_STREAM_WIDTH(32)) dut (
        .aclk(aclk), .resetn(resetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_op(s_req_op),
        .s_req_imm(s_req_imm), .s_req_data(s_req_data),
        .s_payload_axis_tvalid(s_payload_axis_tvalid), .s_payload_axis_tready(s_payload_axis_tready),
        .s_payload_axis_tlast(s_payload_axis_tlast), .s_payload_axis_tdata(s_payload_axis_tdata),
        .m_cmd_axis_tvalid(m_cmd_axis_tvalid), .m_cmd_axis_tready(m_cmd_axis_tready),
        .m_cmd_axis_tlast(m_cmd_axis_tlast), .m_cmd_axis_tdata(m_cmd_axis_tdata),
        .busy(busy), .err(err), .err_clear(err_clear), .cmd_count(cmd_count)
    );

    always #5 aclk = ~aclk;

    vec_t        vecs[12];
    logic [43:0] req_q[$];
    logic [32:0] pay_q[$];
    logic [32:0] exp_q[$];
    int          hs_cyc[$];
    int          tests = 0, fails = 0, cyc = 0, n_out = 0, pay_rdy_cnt = 0;
    bit          req_fire = 0, pay_fire = 0, bp = 0, prev_stall = 0;
    logic [33:0] prev_word = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at posedge+1, observe at negedge.
    task automatic tick();
        logic [32:0] e;
        @(posedge aclk); #1;
        if (req_fire) void'(req_q.pop_front());
        if (pay_fire) void'(pay_q.pop_front());
        s_req_valid = req_q.size() > 0;
        if (s_req_valid) {s_req_op, s_req_imm, s_req_data} = req_q[0];
        s_payload_axis_tvalid = pay_q.size() > 0;
        if (s_payload_axis_tvalid) {s_payload_axis_tlast, s_payload_axis_tdata} = pay_q[0];
        m_cmd_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge aclk);
        cyc++;
        req_fire = s_req_valid && s_req_ready;
        pay_fire = s_payload_axis_tvalid && s_payload_axis_tready;
        if (s_payload_axis_tready) pay_rdy_cnt++;
        if (prev_stall) chk("stall_hold", 64'({m_cmd_axis_tvalid, m_cmd_axis_tlast, m_cmd_axis_tdata}), 64'(prev_word));
        prev_stall = resetn && m_cmd_axis_tvalid && !m_cmd_axis_tready;
        prev_word  = {1'b1, m_cmd_axis_tlast, m_cmd_axis_tdata};
        if (resetn && m_cmd_axis_tvalid && m_cmd_axis_tready) begin
            n_out++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'({m_cmd_axis_tlast, m_cmd_axis_tdata}), 64'hDEAD_0000_0000);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", 64'({m_cmd_axis_tlast, m_cmd_axis_tdata}), 64'(e));
            end
        end
    endtask

    task automatic add_cmd(input vec_t v, input int base);
        req_q.push_back({v.op, v.imm, v.data});
        exp_q.push_back({v.exp_n == 0, v.op, 4'h0, v.imm});
        for (int k = 1; k <= v.exp_n; k++)
            if (v.op == CFG) exp_q.push_back({1'b1, 16'h0, v.data});
            else exp_q.push_back({k == v.exp_n, (k <= v.npay) ? 32'(base + k) : 32'h0});
        for (int k = 1; k <= v.npay; k++)
            pay_q.push_back({v.last_on && k == v.npay, 32'(base + k)});
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_q.size() > 0 || req_q.size() > 0 || pay_q.size() > 0) && n < max) begin
            tick();
            n++;
        end
        tick();
        if (n >= max) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete(); req_q.delete(); pay_q.delete();
        end
    endtask

    initial begin
        vecs[0]  = '{TRI, 24'd48,      16'h0,    12, 1, 12, 2'b00};
        vecs[1]  = '{TEX, 24'h000000,  16'h0,    0,  0, 0,  2'b00};
        vecs[2]  = '{TEX, 24'h000304,  16'h0,    4,  1, 4,  2'b00};
        vecs[3]  = '{CFG, 24'h000000,  16'hBEEF, 0,  0, 1,  2'b00};
        vecs[4]  = '{FB,  24'h000123,  16'h0,    0,  0, 0,  2'b00};
        vecs[5]  = '{FOG, 24'h000000,  16'h0,    10, 1, 33, 2'b01};
        vecs[6]  = '{TRI, 24'd8,       16'h0,    2,  0, 2,  2'b10};
        vecs[7]  = '{4'd7, 24'h000005, 16'h0,    0,  0, 0,  2'b10};
        vecs[8]  = '{NOP, 24'h000000,  16'h0,    0,  0, 0,  2'b00};
        vecs[9]  = '{TRI, 24'd50,      16'h0,    12, 1, 12, 2'b00};
        vecs[10] = '{TEX, 24'h000006,  16'h0,    16, 1, 16, 2'b00};
        vecs[11] = '{FOG, 24'h000000,  16'h0,    33, 1, 33, 2'b00};

        tick(); tick();
        chk("rst_tvalid", 64'(m_cmd_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_cmd_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_cmd_axis_tdata), 64'd0);
        chk("rst_req_ready", 64'(s_req_ready), 64'd0);
        chk("rst_pay_ready", 64'(s_payload_axis_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cmd_count", 64'(cmd_count), 64'd0);
        resetn = 1'b1;
        tick();
        chk("req_ready_after_rst", 64'(s_req_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            pay_rdy_cnt = 0;
            add_cmd(vecs[i], (i + 1) << 8);
            drain(200);
            chk($sformatf("err_v%0d", i), 64'(err), 64'(vecs[i].exp_err));
            if (vecs[i].npay == 0) chk($sformatf("no_pay_ready_v%0d", i), 64'(pay_rdy_cnt), 64'd0);
            if (i == 0) chk("cmd_count_first", 64'(cmd_count), 64'd1);
            err_clear = 1'b1;
            tick();
            err_clear = 1'b0;
            if (vecs[i].exp_err != 2'b00) chk($sformatf("err_cleared_v%0d", i), 64'(err), 64'd0);
        end
        chk("cmd_count_table", 64'(cmd_count), 64'd12);
        chk("busy_idle", 64'(busy), 64'd0);

        hs_cyc.delete();
        add_cmd(vecs[3], 0);
        add_cmd(vecs[4], 0);
        drain(50);
        chk("b2b_words", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) begin
            chk("b2b_gap0", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
            chk("b2b_gap1", 64'(hs_cyc[2] - hs_cyc[1]), 64'd1);
        end
        chk("cmd_count_b2b", 64'(cmd_count), 64'd14);

        bp = 1;
        for (int i = 0; i < 100; i++) add_cmd(vecs[$urandom_range(0, 11)], (i + 16) << 8);
        drain(20000);
        bp = 0;
        chk("cmd_count_random", 64'(cmd_count), 64'd114);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        n_out = 0;
        add_cmd(vecs[0], 'h7700);
        for (int n = 0; n < 100 && n_out < 4; n++) tick();
        chk("pre_reset_words", 64'(n_out >= 4), 64'd1);
        resetn = 1'b0;
        req_q.delete(); pay_q.delete(); exp_q.delete();
        req_fire = 0; pay_fire = 0; prev_stall = 0;
        tick();
        chk("mid_rst_tvalid", 64'(m_cmd_axis_tvalid), 64'd0);
        chk("mid_rst_tlast", 64'(m_cmd_axis_tlast), 64'd0);
        chk("mid_rst_tdata", 64'(m_cmd_axis_tdata), 64'd0);
        chk("mid_rst_pay_ready", 64'(s_payload_axis_tready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_cmd_count", 64'(cmd_count), 64'd0);
        resetn = 1'b1;
        tick();
        chk("post_rst_req_ready", 64'(s_req_ready), 64'd1);
        chk("post_rst_no_tail", 64'(m_cmd_axis_tvalid), 64'd0);
        add_cmd(vecs[2], 'h8800);
        drain(100);
        chk("post_rst_cmd_count", 64'(cmd_count), 64'd1);
        chk("post_rst_err", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cmd_stream_encoder.md
# cmd_stream_encoder

Builds the AXI-Stream command stream consumed by the rasterizer command parser: a command header word carrying opcode and immediate, followed by the exact number of payload words the parser will count from that header, with `tlast` on each command's final word. Sits between the host/DMA side (request channel plus raw payload stream) and the command input of the rendering core. It owns all word counting, so the parser's `streamCounter` can never desynchronise.

## Interface
- `CMD_STREAM_WIDTH`, default 32: command and payload word width in bits; multiple of 16, at least 32.
- `aclk`, in, 1: clock.
- `resetn`, in, 1: reset, synchronous, active-low. Clock is `aclk`.
- `s_req_valid`, in, 1: command request valid.
- `s_req_ready`, out, 1: request accepted when `valid && ready`.
- `s_req_op`, in, `OP_SIZE`: opcode, placed in header bits `[OP_POS +: OP_SIZE]`.
- `s_req_imm`, in, `OP_IMM_SIZE`: immediate, placed in header bits `[0 +: OP_IMM_SIZE]`.
- `s_req_data`, in, 16: render-config value, used only for `OP_RENDER_CONFIG`.
- `s_payload_axis_tvalid` / `tready` / `tlast`, in/out/in, 1: raw payload stream.
- `s_payload_axis_tdata`, in, `CMD_STREAM_WIDTH`: payload word.
- `m_cmd_axis_tvalid` / `tready` / `tlast`, out/in/out, 1: command stream to the parser.
- `m_cmd_axis_tdata`, out, `CMD_STREAM_WIDTH`: command word.
- `busy`, out, 1: high whenever state is not IDLE or `m_cmd_axis_tvalid` is high.
- `err`, out, 2: sticky flags. Bit0: early payload `tlast`. Bit1: missing payload `tlast` or unknown opcode.
- `err_clear`, in, 1: clears `err` for one cycle; a new error set in the same cycle wins.
- `cmd_count`, out, 16: number of commands whose final word has completed, wraps at 65535 -> 0.

## Operation
- Opcode and field constants come from the shared register/descriptor definitions include. `L = log2(CMD_STREAM_WIDTH/8)`.
- Payload word count N, computed at request accept:
  - `OP_TRIANGLE_STREAM`: `imm >> L`. The immediate is a byte count.
  - `OP_TEXTURE_STREAM`: let `s = imm[TEXTURE_STREAM_SIZE_POS +: TEXTURE_STREAM_SIZE_SIZE]` (header field value). N = 0 if `s == 0`, else `1 << (s - L)`.
  - `OP_FOG_LUT_STREAM`: 33.
  - `OP_RENDER_CONFIG`: 1. The word is `s_req_data` zero-extended; the payload stream is not touched.
  - `OP_FRAMEBUFFER`, `OP_NOP_STREAM`: 0.
  - Any other opcode: 0; set `err[1]`.
- Counter is 14 bits. Triangle immediates yielding N > 16383 are a caller error and not checked.
- States:
  - IDLE: `s_req_ready = !m_cmd_axis_tvalid || m_cmd_axis_tready`. On accept, load the header into the output register with `tlast = (N == 0)`. Next state: N == 0 -> IDLE; render config -> CONFIG; else PAYLOAD.
  - CONFIG: when the output slot is free, emit the config word with `tlast = 1`, then go to IDLE.
  - PAYLOAD: `s_payload_axis_tready = !m_cmd_axis_tvalid || m_cmd_axis_tready`. Each transfer copies `tdata` and decrements the counter.
    - On the word where the counter is 1: `tlast = 1`, go to IDLE. If the payload `tlast` was 0, set `err[1]`; the next payload word belongs to the next command.
    - If the payload `tlast` is 1 while the counter is above 1: set `err[0]`, go to PAD.
  - PAD: emit zero words when the slot is free, decrementing the counter. The final word carries `tlast = 1`, then go to IDLE.
- `cmd_count` increments on the output handshake of a `tlast` word.
- `s_payload_axis_tready` is 0 outside PAYLOAD. `s_req_ready` is 0 outside IDLE.

## Timing
- Single output register with pass-through ready; sustains one word per cycle.
- Request accepted in cycle t -> header on `m_cmd_axis` with `tvalid` in cycle t+1.
- Payload word accepted in cycle t -> appears at the output in cycle t+1.
- While `tvalid && !tready`, all `m_cmd_axis` signals hold stable.
- A new request can be accepted in the cycle the previous `tlast` word hands off: back-to-back commands have zero bubbles.
- Reset values: `m_cmd_axis_tvalid` = 0, `m_cmd_axis_tlast` = 0, `m_cmd_axis_tdata` = 0, `s_req_ready` = 0, `s_payload_axis_tready` = 0, `busy` = 0, `err` = 0, `cmd_count` = 0, state = IDLE.
- `s_req_ready` may rise combinationally from the first cycle after reset.
- Reset mid-command drops the partial command immediately; no tail is emitted after reset.

## Test plan
- W=32, request `OP_TRIANGLE_STREAM` with imm = 48, 12 payload words 1..12 with `tlast` on word 12 -> output is header then words 1..12, `tlast` only on word 12, `err` = 0, `cmd_count` = 1.
- `OP_TEXTURE_STREAM` with size field 0 -> single header word with `tlast`; payload `tready` never asserts. Repeat with size field 4 at W=32 -> 4 payload words.
- `OP_RENDER_CONFIG` with `s_req_data` = 0xBEEF, followed back-to-back by `OP_FRAMEBUFFER` -> output is header, 0x0000BEEF (`tlast`), framebuffer header (`tlast`), with no idle cycle between them.
- `OP_FOG_LUT_STREAM` with payload `tlast` on word 10 -> words 1..10, then 23 zero words, `tlast` on output word 33 of the payload, `err[0]` = 1; `err_clear` returns `err` to 0.
- Random `m_cmd_axis_tready` backpressure (50%) over 100 mixed commands -> output equals the reference model word for word, and `tdata`/`tlast` never change while stalled.
- Assert `resetn` low mid-PAYLOAD for one cycle -> next cycle all outputs are at reset values; the next request produces a clean header.
